// File: rtl/alu_src_sequencer_pkg.sv
// Shared encodings for the multicycle control slice: FSM states, opcode/funct values and
// the ALUSrcA/ALUSrcB/ALUOp codes that the datapath muxes and the ALU decode.
package alu_src_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC_R, ST_EXEC_I, ST_MEM_ADDR,
    ST_MEM_WAIT, ST_EXEC_M, ST_BRANCH, ST_DONE, ST_ILLEGAL
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDM  = 6'h01;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {SRCA_PC = 2'd0, SRCA_A = 2'd1, SRCA_MDR = 2'd2} srca_e;
  typedef enum logic [2:0] {
    SRCB_B = 3'd0, SRCB_FOUR = 3'd1, SRCB_IMM = 3'd2, SRCB_MDR = 3'd3, SRCB_IMM_SL2 = 3'd4
  } srcb_e;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3, ALU_SLT = 3'd4
  } aluop_e;

  typedef enum logic [1:0] {MEM_LW, MEM_SW, MEM_ADDM} mem_kind_e;

  typedef struct packed {
    srca_e  src_a;
    srcb_e  src_b;
    aluop_e alu_op;
    logic   ir_write;
    logic   pc_write;
    logic   pc_write_cond;
    logic   busy;
    logic   done;
    logic   illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    src_a: SRCA_PC, src_b: SRCB_B, alu_op: ALU_ADD, ir_write: 1'b0, pc_write: 1'b0,
    pc_write_cond: 1'b0, busy: 1'b0, done: 1'b0, illegal: 1'b0
  };

endpackage

// File: rtl/alu_src_sequencer_alu_op_decode.sv
// R-type funct field to ALU operation; unknown funct codes raise funct_illegal and map to ADD.
module alu_op_decode
  import alu_src_sequencer_pkg::*;
(
  input  logic [5:0] funct,
  output aluop_e     alu_op,
  output logic       funct_illegal
);

  always_comb begin
    alu_op        = ALU_ADD;
    funct_illegal = 1'b0;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: funct_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_src_sequencer.sv
// Multicycle instruction sequencer driving operand-mux selects and ALU control.
// state     | meaning
// IDLE      | waiting for start
// FETCH     | PC+4, wait for instruction word
// DECODE    | branch target precompute, dispatch on opcode
// EXEC_R    | R-type ALU operation
// EXEC_I    | addi
// MEM_ADDR  | effective address
// MEM_WAIT  | wait for MDR
// EXEC_M    | A + MDR (addm)
// BRANCH    | beq compare
// DONE      | retire pulse
// ILLEGAL   | abort pulse
module alu_src_sequencer
  import alu_src_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic [1:0] ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       busy,
  output logic       done,
  output logic       illegal
);

  state_e    state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  mem_kind_e mem_kind_q, mem_kind_d;
  ctrl_t     ctrl_q, ctrl_d;
  aluop_e    r_alu_op;
  logic      funct_illegal;
  logic      wait_tc;

  alu_op_decode u_alu_op_decode (
    .funct         (funct),
    .alu_op        (r_alu_op),
    .funct_illegal (funct_illegal)
  );

  assign wait_tc = (({1'b0, wait_cnt_q} + 5'd1) == 5'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      mem_kind_q <= MEM_LW;
      ctrl_q     <= CTRL_IDLE;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_kind_q <= mem_kind_d;
      ctrl_q     <= ctrl_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_kind_d = mem_kind_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d    = ST_FETCH;
        wait_cnt_d = 4'd0;
      end
      // mem_ready on the terminal-count cycle still completes the access
      ST_FETCH: begin
        if (mem_ready)    state_d = ST_DECODE;
        else if (wait_tc) state_d = ST_ILLEGAL;
        else              wait_cnt_d = wait_cnt_q + 4'd1;
      end
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE: state_d = ST_EXEC_R;
          OP_ADDI:  state_d = ST_EXEC_I;
          OP_LW:    begin state_d = ST_MEM_ADDR; mem_kind_d = MEM_LW;   end
          OP_SW:    begin state_d = ST_MEM_ADDR; mem_kind_d = MEM_SW;   end
          OP_ADDM:  begin state_d = ST_MEM_ADDR; mem_kind_d = MEM_ADDM; end
          OP_BEQ:   state_d = ST_BRANCH;
          default:  state_d = ST_ILLEGAL;
        endcase
      end
      ST_EXEC_R: state_d = funct_illegal ? ST_ILLEGAL : ST_DONE;
      ST_MEM_ADDR: begin
        if (mem_kind_q == MEM_SW) state_d = ST_DONE;
        else begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 4'd0;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready)    state_d = (mem_kind_q == MEM_ADDM) ? ST_EXEC_M : ST_DONE;
        else if (wait_tc) state_d = ST_ILLEGAL;
        else              wait_cnt_d = wait_cnt_q + 4'd1;
      end
      ST_EXEC_I, ST_EXEC_M, ST_BRANCH: state_d = ST_DONE;
      ST_DONE, ST_ILLEGAL:             state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl_d      = CTRL_IDLE;
    ctrl_d.busy = (state_q != ST_IDLE);
    case (state_q)
      ST_FETCH: begin
        ctrl_d.src_b    = SRCB_FOUR;
        ctrl_d.ir_write = mem_ready;
        ctrl_d.pc_write = mem_ready;
      end
      ST_DECODE: ctrl_d.src_b = SRCB_IMM_SL2;
      ST_EXEC_R: begin
        ctrl_d.src_a  = SRCA_A;
        ctrl_d.alu_op = r_alu_op;
      end
      ST_EXEC_I, ST_MEM_ADDR, ST_MEM_WAIT: begin
        ctrl_d.src_a = SRCA_A;
        ctrl_d.src_b = SRCB_IMM;
      end
      ST_EXEC_M: begin
        ctrl_d.src_a = SRCA_A;
        ctrl_d.src_b = SRCB_MDR;
      end
      ST_BRANCH: begin
        ctrl_d.src_a         = SRCA_A;
        ctrl_d.alu_op        = ALU_SUB;
        ctrl_d.pc_write_cond = 1'b1;
      end
      ST_DONE:    ctrl_d.done    = 1'b1;
      ST_ILLEGAL: ctrl_d.illegal = 1'b1;
      default: ;
    endcase
  end

  assign ALUSrcA     = ctrl_q.src_a;
  assign ALUSrcB     = ctrl_q.src_b;
  assign ALUOp       = ctrl_q.alu_op;
  assign IRWrite     = ctrl_q.ir_write;
  assign PCWrite     = ctrl_q.pc_write;
  assign PCWriteCond = ctrl_q.pc_write_cond;
  assign busy        = ctrl_q.busy;
  assign done        = ctrl_q.done;
  assign illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_alu_src_sequencer.sv
// Directed bench for alu_src_sequencer: per-opcode vector table plus multi-cycle corner sequences.
module tb_alu_src_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       mem_ready = 1'b0;
  logic [1:0] ALUSrcA;
  logic [2:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic       IRWrite, PCWrite, PCWriteCond, busy, done, illegal;

  int n_cmp = 0;
  int n_err = 0;

  alu_src_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] opc;
    logic [5:0] fn;
    int a4;
    int b4;
    int op4;
    int done_cyc;
    int ill_cyc;
    int pcc_cnt;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int all_outs();
    return int'({ALUSrcA, ALUSrcB, ALUOp, IRWrite, PCWrite, PCWriteCond, busy, done, illegal});
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int done_c, ill_c, ir_c, pcc_c, done_n, end_c;
    int a4, b4, op4;
    logic bz [14];
    done_c = 0; ill_c = 0; ir_c = 0; pcc_c = 0; done_n = 0; a4 = -1; b4 = -1; op4 = -1;
    opcode = v.opc; funct = v.fn; mem_ready = 1'b1; start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      start = 1'b0;
      bz[k] = busy;
      if (done) begin done_n++; if (done_c == 0) done_c = k; end
      if (illegal && ill_c == 0) ill_c = k;
      if (IRWrite) ir_c++;
      if (PCWriteCond) pcc_c++;
      if (k == 4) begin a4 = int'(ALUSrcA); b4 = int'(ALUSrcB); op4 = int'(ALUOp); end
    end
    chk($sformatf("v%0d srcA@4", idx), a4, v.a4);
    chk($sformatf("v%0d srcB@4", idx), b4, v.b4);
    chk($sformatf("v%0d aluop@4", idx), op4, v.op4);
    chk($sformatf("v%0d done_cyc", idx), done_c, v.done_cyc);
    chk($sformatf("v%0d done_width", idx), done_n, (v.done_cyc != 0) ? 1 : 0);
    chk($sformatf("v%0d illegal_cyc", idx), ill_c, v.ill_cyc);
    chk($sformatf("v%0d irwrite_cnt", idx), ir_c, 1);
    chk($sformatf("v%0d pcwcond_cnt", idx), pcc_c, v.pcc_cnt);
    end_c = (v.done_cyc != 0) ? v.done_cyc : v.ill_cyc;
    chk($sformatf("v%0d busy@end", idx), int'(bz[end_c]), 1);
    chk($sformatf("v%0d busy@end+1", idx), int'(bz[end_c + 1]), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_c, ill_c, ir_c, pw_c, b2_c, busy_late, done_n;

    //             opc    fn    A  B  op done ill pcc
    vecs[0]  = '{6'h00, 6'h20, 1, 0, 0, 5, 0, 0};
    vecs[1]  = '{6'h00, 6'h22, 1, 0, 1, 5, 0, 0};
    vecs[2]  = '{6'h00, 6'h24, 1, 0, 2, 5, 0, 0};
    vecs[3]  = '{6'h00, 6'h25, 1, 0, 3, 5, 0, 0};
    vecs[4]  = '{6'h00, 6'h2A, 1, 0, 4, 5, 0, 0};
    vecs[5]  = '{6'h00, 6'h21, 1, 0, 0, 0, 5, 0};
    vecs[6]  = '{6'h08, 6'h00, 1, 2, 0, 5, 0, 0};
    vecs[7]  = '{6'h2B, 6'h00, 1, 2, 0, 5, 0, 0};
    vecs[8]  = '{6'h23, 6'h00, 1, 2, 0, 6, 0, 0};
    vecs[9]  = '{6'h01, 6'h00, 1, 2, 0, 7, 0, 0};
    vecs[10] = '{6'h04, 6'h00, 1, 0, 1, 5, 0, 1};
    vecs[11] = '{6'h3F, 6'h00, 0, 0, 0, 0, 4, 0};

    reset = 1'b0;
    #22;
    chk("reset all outputs", all_outs(), 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("idle after reset", all_outs(), 0);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // lw with three stalled cycles in MEM_WAIT
    opcode = 6'h23; funct = 6'h00;
    done_c = 0; b2_c = 0;
    for (int k = 1; k <= 12; k++) begin
      mem_ready = (k >= 5 && k <= 7) ? 1'b0 : 1'b1;
      start = (k == 1);
      tick();
      if (done && done_c == 0) done_c = k;
      if (k >= 4 && k <= 8 && ALUSrcB == 3'd2) b2_c++;
    end
    start = 1'b0;
    chk("lw stall done_cyc", done_c, 9);
    chk("lw stall srcB=2 held", b2_c, 5);

    // addm select sequence and busy release
    opcode = 6'h01; mem_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    begin
      int exp_b [5] = '{1, 4, 2, 2, 3};
      for (int k = 0; k < 5; k++) begin
        tick();
        chk($sformatf("addm srcB step%0d", k), int'(ALUSrcB), exp_b[k]);
      end
    end
    tick();
    chk("addm done pulse", int'(done), 1);
    tick();
    chk("addm done cleared", int'(done), 0);
    chk("addm busy dropped", int'(busy), 0);
    tick();

    // 15 low cycles in FETCH -> timeout; a start while busy must not queue
    opcode = 6'h00; funct = 6'h20;
    ill_c = 0; ir_c = 0; pw_c = 0; busy_late = 0; done_n = 0;
    for (int k = 1; k <= 24; k++) begin
      mem_ready = 1'b0;
      start = (k == 1 || k == 5);
      tick();
      if (illegal && ill_c == 0) ill_c = k;
      if (IRWrite) ir_c++;
      if (PCWrite) pw_c++;
      if (done) done_n++;
      if (k >= 18 && busy) busy_late++;
    end
    start = 1'b0;
    chk("timeout illegal_cyc", ill_c, 17);
    chk("timeout irwrite_cnt", ir_c, 0);
    chk("timeout pcwrite_cnt", pw_c, 0);
    chk("timeout no done", done_n, 0);
    chk("start during busy ignored", busy_late, 0);

    // mem_ready arriving on the terminal-count cycle completes the fetch
    done_c = 0; ill_c = 0; ir_c = 0;
    for (int k = 1; k <= 24; k++) begin
      mem_ready = (k >= 2 && k <= 15) ? 1'b0 : 1'b1;
      start = (k == 1);
      tick();
      if (done && done_c == 0) done_c = k;
      if (illegal && ill_c == 0) ill_c = k;
      if (IRWrite) ir_c++;
    end
    start = 1'b0;
    chk("tc-ready done_cyc", done_c, 19);
    chk("tc-ready no illegal", ill_c, 0);
    chk("tc-ready irwrite_cnt", ir_c, 1);

    // reset in the middle of a stalled FETCH
    mem_ready = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    chk("pre-reset busy", int'(busy), 1);
    chk("pre-reset srcB fetch", int'(ALUSrcB), 1);
    #2 reset = 1'b0;
    #1;
    chk("mid-fetch reset outputs", all_outs(), 0);
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    ir_c = 0; busy_late = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (IRWrite) ir_c++;
      if (busy) busy_late++;
    end
    chk("post-reset no irwrite", ir_c, 0);
    chk("post-reset stays idle", busy_late, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
